// File: rtl/ult_share_pkg.sv
// Shared types and defaults for the round-robin less-than scheduler.
// ULT_SHARE_SCHED_EQ_EN adds the equality flag to the response record.
package ult_share_pkg;

    localparam int N_DEF    = 4;
    localparam int W_DEF    = 2;
    localparam int ID_MAX_W = 4;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Sized for the largest supported requester count; narrower builds use the low bits.
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic                lt;
`ifdef ULT_SHARE_SCHED_EQ_EN
        logic                eq;
`endif
    } resp_t;

endpackage

// File: rtl/ult_sub_unit.sv
// Single W-bit subtract-with-carry chain: {cout, d} = a + ~b + 1.
// cout == 0 means a < b (unsigned).
module ult_sub_unit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         cout,
    output logic [W-1:0] d
);

    assign {cout, d} = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

endmodule

// File: rtl/ult_share_sched.sv
// Round-robin scheduler sharing one unsigned less-than unit among N requesters.
// Define ULT_SHARE_SCHED_EQ_EN to add the registered RESP_EQ output.
module ult_share_sched
    import ult_share_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int IDW = id_width(N)
) (
    input  logic           CLK,
    input  logic           RESETN,
    input  logic [N-1:0]   REQ_VALID,
    input  logic [N*W-1:0] REQ_A,
    input  logic [N*W-1:0] REQ_B,
    output logic [N-1:0]   REQ_READY,
    output logic           RESP_VALID,
    output logic [IDW-1:0] RESP_ID,
    output logic           RESP_LT,
`ifdef ULT_SHARE_SCHED_EQ_EN
    output logic           RESP_EQ,
`endif
    input  logic           RESP_READY,
    output logic           BUSY
);

    logic [IDW-1:0] ptr;
    logic           vld_p1;
    logic           vld_p2;
    logic [W-1:0]   a_p1;
    logic [W-1:0]   b_p1;
    logic [IDW-1:0] id_p1;
    resp_t          resp_p2;

    logic           s1_free;
    logic           s2_free;
    logic           accept;
    logic [N-1:0]   req_rot;
    logic           grant_found;
    logic [IDW-1:0] grant_off;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   grant_oh;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           cmp_cout;
    logic [W-1:0]   cmp_diff;

    assign s2_free = !vld_p2 || RESP_READY;
    assign s1_free = !vld_p1 || s2_free;

    // Rotate so bit 0 is the requester at the pointer; the lowest set bit wins.
    assign req_rot = N'({REQ_VALID, REQ_VALID} >> ptr);

    always_comb begin
        logic [IDW:0] sum;
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = IDW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, grant_off};
        if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
        end
        grant_id = IDW'(sum);
    end

    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int k = 0; k < N; k++) begin
            grant_oh[k] = grant_found && (grant_id == IDW'(k));
            if (grant_oh[k]) begin
                sel_a = REQ_A[k*W +: W];
                sel_b = REQ_B[k*W +: W];
            end
        end
    end

    // RESETN gates the strobe so no requester sees a grant while held in reset.
    assign accept    = grant_found && s1_free && RESETN;
    assign REQ_READY = accept ? grant_oh : '0;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
            end
            if (s1_free) begin
                vld_p1 <= accept;
            end
            if (s2_free) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // Stage p1: grant and operand capture
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_p1  <= sel_a;
            b_p1  <= sel_b;
            id_p1 <= grant_id;
        end
    end

    ult_sub_unit #(
        .W (W)
    ) u_sub (
        .a    (a_p1),
        .b    (b_p1),
        .cout (cmp_cout),
        .d    (cmp_diff)
    );

    // Stage p2: registered compare result
    always_ff @(posedge CLK) begin
        if (s2_free && vld_p1) begin
            resp_p2.id <= ID_MAX_W'(id_p1);
            resp_p2.lt <= !cmp_cout;
`ifdef ULT_SHARE_SCHED_EQ_EN
            resp_p2.eq <= cmp_cout && (cmp_diff == '0);
`endif
        end
    end

`ifndef ULT_SHARE_SCHED_EQ_EN
    logic unused_diff;
    assign unused_diff = ^cmp_diff;
`endif
    logic unused_id_hi;
    assign unused_id_hi = ^resp_p2.id;

    // Data registers are not reset; gating by the valid bit keeps outputs 0 when empty.
    assign RESP_VALID = vld_p2;
    assign RESP_ID    = vld_p2 ? resp_p2.id[IDW-1:0] : '0;
    assign RESP_LT    = vld_p2 && resp_p2.lt;
`ifdef ULT_SHARE_SCHED_EQ_EN
    assign RESP_EQ    = vld_p2 && resp_p2.eq;
`endif
    assign BUSY       = vld_p1 || vld_p2;

endmodule

// File: tb/tb_ult_share_sched.sv
// Scoreboard bench for ult_share_sched (N=4, W=2); honours ULT_SHARE_SCHED_EQ_EN.
module tb_ult_share_sched;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int IDW = 2;

    typedef struct {
        int   id;
        logic lt;
        logic eq;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [IDW-1:0] resp_id;
    logic           resp_lt;
    logic           resp_ready;
    logic           busy;
`ifdef ULT_SHARE_SCHED_EQ_EN
    logic           resp_eq;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic exp_lt [N];
    logic exp_eq [N];
    logic [N-1:0] hs_mask = '0;

    always #5 clk = ~clk;

    ult_share_sched #(.N(N), .W(W)) dut (
        .CLK        (clk),
        .RESETN     (rst_n),
        .REQ_VALID  (req_valid),
        .REQ_A      (req_a),
        .REQ_B      (req_b),
        .REQ_READY  (req_ready),
        .RESP_VALID (resp_valid),
        .RESP_ID    (resp_id),
        .RESP_LT    (resp_lt),
`ifdef ULT_SHARE_SCHED_EQ_EN
        .RESP_EQ    (resp_eq),
`endif
        .RESP_READY (resp_ready),
        .BUSY       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake side: record the expected response of every accepted request.
    always @(negedge clk) begin
        logic [N-1:0] m;
        m = '0;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{id: i, lt: exp_lt[i], eq: exp_eq[i]});
                    m[i] = 1'b1;
                end
            end
        end
        hs_mask <= m;
    end

    // Response side: pop and compare whenever a result is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got id %0d, expected no response", resp_id);
            end else begin
                e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_lt", 32'(resp_lt), 32'(e.lt));
`ifdef ULT_SHARE_SCHED_EQ_EN
                check("resp_eq", 32'(resp_eq), 32'(e.eq));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input logic lt, input logic eq);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = W'(a);
        req_b[i*W +: W]  = W'(b);
        exp_lt[i]        = lt;
        exp_eq[i]        = eq;
    endtask

    task automatic send_one(input int i, input int a, input int b, input logic lt, input logic eq);
        bit got;
        got = 1'b0;
        set_req(i, a, b, lt, eq);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        check("grant_wait", 32'(got), 32'(1));
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_idle", 32'(busy), 32'(0));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exhausted, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   a, b;
        int   seq [6];
        seq = '{0, 1, 2, 3, 0, 1};
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_lt[i] = 1'b0;
            exp_eq[i] = 1'b0;
        end

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'(0));
        check("idle_resp_id", 32'(resp_id), 32'(0));
        check("idle_resp_lt", 32'(resp_lt), 32'(0));
        tick();

        // Single request from requester 1: A=1 B=2
        set_req(1, 1, 2, 1'b1, 1'b0);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("single_ready_drop", 32'(req_ready), 32'(0));
        check("single_s1_only", 32'(resp_valid), 32'(0));
        check("single_busy", 32'(busy), 32'(1));
        tick();
        @(negedge clk);
        check("single_resp_valid", 32'(resp_valid), 32'(1));
        check("single_resp_id", 32'(resp_id), 32'(1));
        check("single_resp_lt", 32'(resp_lt), 32'(1));
        tick();
        @(negedge clk);
        check("single_resp_gone", 32'(resp_valid), 32'(0));
        check("single_idle", 32'(busy), 32'(0));
        tick();

        // Boundary operand pairs on requester 2
        send_one(2, 0, 3, 1'b1, 1'b0);
        send_one(2, 3, 0, 1'b0, 1'b0);
        send_one(2, 2, 2, 1'b0, 1'b1);
        wait_idle();

        // Backpressure: pointer is at 3, so grants go 3 then 0, then stall
        resp_ready = 1'b0;
        set_req(0, 0, 3, 1'b1, 1'b0);
        set_req(1, 1, 2, 1'b1, 1'b0);
        set_req(2, 2, 1, 1'b0, 1'b0);
        set_req(3, 3, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_grant0", 32'(req_ready), 32'(4'b1000));
        tick();
        @(negedge clk);
        check("bp_grant1", 32'(req_ready), 32'(4'b0001));
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_zero", 32'(req_ready), 32'(0));
            check("bp_hold_valid", 32'(resp_valid), 32'(1));
            check("bp_hold_id", 32'(resp_id), 32'(3));
            check("bp_hold_lt", 32'(resp_lt), 32'(0));
            check("bp_busy", 32'(busy), 32'(1));
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_first", 32'(resp_id), 32'(3));
        tick();
        @(negedge clk);
        check("bp_release_second_valid", 32'(resp_valid), 32'(1));
        check("bp_release_second_id", 32'(resp_id), 32'(0));
        check("bp_release_second_lt", 32'(resp_lt), 32'(1));
        wait_idle();

        // Reset with both stages full; in-flight entries must vanish
        resp_ready = 1'b0;
        set_req(0, 0, 3, 1'b1, 1'b0);
        set_req(1, 1, 2, 1'b1, 1'b0);
        set_req(2, 2, 1, 1'b0, 1'b0);
        set_req(3, 3, 0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("full_busy", 32'(busy), 32'(1));
        check("full_resp_valid", 32'(resp_valid), 32'(1));
        check("full_ready_zero", 32'(req_ready), 32'(0));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
        check("mid_rst_resp_id", 32'(resp_id), 32'(0));
        check("mid_rst_resp_lt", 32'(resp_lt), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_req_ready", 32'(req_ready), 32'(0));
        sb.delete();
        @(posedge clk);
        #3;
        rst_n      = 1'b1;
        resp_ready = 1'b1;

        // All four valid continuously: strict rotation starting at 0
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(N'(1) << seq[k]));
            if (k == 0) check("post_rst_no_resp", 32'(resp_valid), 32'(0));
        end
        tick();
        req_valid = '0;
        wait_idle();

        // Random traffic with random backpressure and withdrawn requests
        for (int c = 0; c < 1500; c++) begin
            resp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs_mask[i] || $urandom_range(7) == 0) begin
                    if ($urandom_range(2) != 0) begin
                        a = int'($urandom_range(3));
                        b = int'($urandom_range(3));
                        set_req(i, a, b, a < b, a == b);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_idle();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
